rr_arb_enc: RTL and testbench

Round-robin arbiter with an encoded grant output, the index-producing counterpart of the one-hot decoders in the deu toolbox.
- Arbitrates N level-sensitive request lines.
- Registers the winner as a binary index plus its matching one-hot vector.
- Holds each grant under a valid/ready handshake until the consumer accepts it.
- Used by the decode stage to pick among instruction-buffer slots and to share one port among several sources.

---
 rtl/rr_arb_enc_pkg.sv | 18 +
 rtl/rr_arb_enc_if.sv | 29 ++
 rtl/rr_arb_enc_prio_enc.sv | 36 +++
 rtl/rr_arb_enc.sv | 94 +++++++++
 tb/tb_rr_arb_enc.sv | 119 +++++++++++
 5 files changed

// File: rtl/rr_arb_enc_pkg.sv
// Shared types and helpers for the round-robin encoded-grant arbiter.
// Holds the default width parameters, the FSM state type and a one-hot check used by assertions.
package rr_arb_enc_pkg;

   localparam int DEF_N    = 4;
   localparam int DEF_IDXW = $clog2(DEF_N);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // True when at most one bit is set.
   function automatic logic is_onehot0(input logic [63:0] v);
      return (v & (v - 64'd1)) == 64'd0;
   endfunction

endpackage

// File: rtl/rr_arb_enc_if.sv
// Request/grant bundle between requesters, the arbiter (master) and the grant consumer (slave).
// The grant side is valid/ready; requests are level-sensitive.
interface rr_arb_enc_if #(
   parameter int N = 4
);
   localparam int IDXW = $clog2(N);

   logic [N-1:0]    req;
   logic            gnt_ready;
   logic            gnt_valid;
   logic [IDXW-1:0] gnt_idx;
   logic [N-1:0]    gnt_onehot;

   modport master (
      input  req,
      input  gnt_ready,
      output gnt_valid,
      output gnt_idx,
      output gnt_onehot
   );

   modport slave (
      output req,
      output gnt_ready,
      input  gnt_valid,
      input  gnt_idx,
      input  gnt_onehot
   );
endinterface

// File: rtl/rr_arb_enc_prio_enc.sv
// Rotating priority encoder: first set bit of i_cand searching upward from i_ptr with wrap.
// Purely combinational, zero latency; no flow control.
module rr_prio_enc #(
   parameter int N    = 4,
   parameter int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    i_cand,
   input  logic [IDXW-1:0] i_ptr,
   output logic            o_found,
   output logic [IDXW-1:0] o_idx
);

   logic [2*N-1:0]  w_dbl;
   logic [N-1:0]    w_rot;
   logic [IDXW-1:0] w_off;
   logic            w_any;

   // Doubling the vector makes the rotate a plain part-select.
   assign w_dbl = {i_cand, i_cand};
   assign w_rot = w_dbl[i_ptr +: N];

   always_comb begin
      w_off = '0;
      w_any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = IDXW'(i);
            w_any = 1'b1;
         end
      end
   end

   assign o_found = w_any;
   assign o_idx   = i_ptr + w_off;

endmodule

// File: rtl/rr_arb_enc.sv
// Round-robin arbiter presenting a registered binary + one-hot grant; grant appears 1 cycle after req.
// A grant is held stable until gnt_ready; each accepted grant may be followed by another the next cycle.
module rr_arb_enc
   import rr_arb_enc_pkg::*;
#(
   parameter int N = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   rr_arb_enc_if.master  arb
);

   localparam int IDXW = $clog2(N);

   state_t          r_state;
   logic [IDXW-1:0] r_ptr;
   logic            r_valid;
   logic [IDXW-1:0] r_idx;
   logic [N-1:0]    r_onehot;

   logic            w_hs;
   logic [N-1:0]    w_cand;
   logic [IDXW-1:0] w_ptr_nxt;
   logic            w_found;
   logic [IDXW-1:0] w_win_idx;
   logic [N-1:0]    w_win_onehot;

   assign w_hs      = (r_state == ST_GRANT) && arb.gnt_ready;
   assign w_ptr_nxt = w_hs ? (r_idx + IDXW'(1)) : r_ptr;
   // The requester just served sits out the re-arbitration of its own accept cycle.
   assign w_cand    = (r_state == ST_GRANT) ? (arb.req & ~r_onehot) : arb.req;

   rr_prio_enc #(
      .N    (N),
      .IDXW (IDXW)
   ) u_prio_enc (
      .i_cand  (w_cand),
      .i_ptr   (w_ptr_nxt),
      .o_found (w_found),
      .o_idx   (w_win_idx)
   );

   assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_valid  <= 1'b0;
         r_idx    <= '0;
         r_onehot <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_state  <= ST_GRANT;
                  r_valid  <= 1'b1;
                  r_idx    <= w_win_idx;
                  r_onehot <= w_win_onehot;
               end
            end
            ST_GRANT: begin
               if (arb.gnt_ready) begin
                  r_ptr <= w_ptr_nxt;
                  if (w_found) begin
                     r_idx    <= w_win_idx;
                     r_onehot <= w_win_onehot;
                  end else begin
                     r_state  <= ST_IDLE;
                     r_valid  <= 1'b0;
                     r_onehot <= '0;
                  end
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_valid  <= 1'b0;
               r_onehot <= '0;
            end
         endcase
      end
   end

   assign arb.gnt_valid  = r_valid;
   assign arb.gnt_idx    = r_idx;
   assign arb.gnt_onehot = r_onehot;

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (r_valid && !arb.gnt_ready) |=> ($stable(r_idx) && $stable(r_onehot)));

   a_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      is_onehot0(64'(r_onehot)));

endmodule

// File: tb/tb_rr_arb_enc.sv
// Directed bench for rr_arb_enc: hand-written reset sequence plus a table of per-cycle vectors.
module tb_rr_arb_enc;

   logic clk;
   logic rst_n;

   rr_arb_enc_if #(.N(4)) bus ();

   rr_arb_enc #(.N(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .arb   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [3:0] req;
      logic       rdy;
      logic       ev;
      logic [1:0] eidx;
      logic [3:0] eoh;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic [1:0] eidx, input logic [3:0] eoh);
      chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(ev));
      chk({tag, ".onehot"}, 32'(bus.gnt_onehot), 32'(eoh));
      if (ev) chk({tag, ".idx"}, 32'(bus.gnt_idx), 32'(eidx));
   endtask

   function automatic vec_t mk(bit rst, logic [3:0] req, logic rdy, logic ev, logic [1:0] eidx, logic [3:0] eoh);
      vec_t v;
      v.rst = rst; v.req = req; v.rdy = rdy; v.ev = ev; v.eidx = eidx; v.eoh = eoh;
      return v;
   endfunction

   vec_t vecs[18];

   initial begin
      // single request then release
      vecs[0]  = mk(1, 4'b0100, 1, 1, 2'd2, 4'b0100);
      vecs[1]  = mk(0, 4'b0000, 1, 0, 2'd0, 4'b0000);
      // fairness with all requesting
      vecs[2]  = mk(1, 4'b1111, 1, 1, 2'd0, 4'b0001);
      vecs[3]  = mk(0, 4'b1111, 1, 1, 2'd1, 4'b0010);
      vecs[4]  = mk(0, 4'b1111, 1, 1, 2'd2, 4'b0100);
      vecs[5]  = mk(0, 4'b1111, 1, 1, 2'd3, 4'b1000);
      vecs[6]  = mk(0, 4'b1111, 1, 1, 2'd0, 4'b0001);
      vecs[7]  = mk(0, 4'b1111, 1, 1, 2'd1, 4'b0010);
      // backpressure hold, req change ignored while held
      vecs[8]  = mk(1, 4'b1010, 0, 1, 2'd1, 4'b0010);
      vecs[9]  = mk(0, 4'b1010, 0, 1, 2'd1, 4'b0010);
      vecs[10] = mk(0, 4'b1000, 0, 1, 2'd1, 4'b0010);
      vecs[11] = mk(0, 4'b1000, 1, 1, 2'd3, 4'b1000);
      // wrap from 3 to 0 with the served requester masked
      vecs[12] = mk(0, 4'b1001, 1, 1, 2'd0, 4'b0001);
      vecs[13] = mk(0, 4'b1001, 1, 1, 2'd3, 4'b1000);
      vecs[14] = mk(0, 4'b0000, 1, 0, 2'd0, 4'b0000);
      // sole requester: one bubble then re-grant
      vecs[15] = mk(0, 4'b0010, 1, 1, 2'd1, 4'b0010);
      vecs[16] = mk(0, 4'b0010, 1, 0, 2'd0, 4'b0000);
      vecs[17] = mk(0, 4'b0010, 1, 1, 2'd1, 4'b0010);

      rst_n = 1'b0;
      bus.req = '0;
      bus.gnt_ready = 1'b0;
      #12;
      chk("rst.valid", 32'(bus.gnt_valid), 32'd0);
      chk("rst.idx", 32'(bus.gnt_idx), 32'd0);
      chk("rst.onehot", 32'(bus.gnt_onehot), 32'd0);

      // async reset mid-grant
      @(negedge clk);
      rst_n = 1'b1;
      bus.req = 4'b0100;
      @(posedge clk); #1;
      chk_out("pre_arst", 1'b1, 2'd2, 4'b0100);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.valid", 32'(bus.gnt_valid), 32'd0);
      chk("arst.onehot", 32'(bus.gnt_onehot), 32'd0);
      chk("arst.idx", 32'(bus.gnt_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.req = 4'b0001;
      @(posedge clk); #1;
      chk_out("post_arst", 1'b1, 2'd0, 4'b0001);

      for (int i = 0; i < 18; i++) begin
         if (vecs[i].rst) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
         end
         bus.req = vecs[i].req;
         bus.gnt_ready = vecs[i].rdy;
         @(posedge clk); #1;
         chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eidx, vecs[i].eoh);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
